// File: rtl/sb_reg_access_ctrl.sv
// Sideband register-file access controller: round-robin arbitration between the link FSM
// and the remote sideband handler, byte-serialised writes and 24-bit reads with ack/err.
module sb_reg_access_ctrl #(
   parameter int MAX_ADDR = 156,
   parameter int ADDR_W   = 8
) (
   input  logic              fsm_clk,
   input  logic              rst,

   input  logic              r0_req,
   input  logic              r0_write,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [1:0]        r0_len,
   input  logic [23:0]       r0_wdata,
   output logic              r0_ack,
   output logic              r0_err,
   output logic [23:0]       r0_rdata,

   input  logic              r1_req,
   input  logic              r1_write,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [1:0]        r1_len,
   input  logic [23:0]       r1_wdata,
   output logic              r1_ack,
   output logic              r1_err,
   output logic [23:0]       r1_rdata,

   output logic              s_read,
   output logic              s_write,
   output logic [ADDR_W-1:0] s_address,
   output logic [7:0]        s_data,
   input  logic [23:0]       sb_read
);

   typedef enum logic [2:0] {IDLE, WR, RD, RDWAIT, DONE} state_t;
   typedef logic [ADDR_W:0] ext_addr_t;

   localparam ext_addr_t MAX_EXT = ext_addr_t'(MAX_ADDR);

   state_t            state, state_nxt;
   logic              last_grant, last_grant_nxt;
   logic              gnt, gnt_nxt;
   logic [ADDR_W-1:0] lat_addr, lat_addr_nxt;
   logic [1:0]        lat_len, lat_len_nxt;
   logic [23:0]       lat_wdata, lat_wdata_nxt;
   logic [1:0]        k, k_nxt, k_inc;

   logic              s_read_nxt, s_write_nxt;
   logic [ADDR_W-1:0] s_address_nxt;
   logic [7:0]        s_data_nxt;
   logic              r0_ack_nxt, r0_err_nxt, r1_ack_nxt, r1_err_nxt;

   logic              req_any, grant_id, sel_write, sel_fail;
   logic [ADDR_W-1:0] sel_addr;
   logic [1:0]        sel_len;
   logic [23:0]       sel_wdata;

   function automatic logic [7:0] byte_of(input logic [23:0] w, input logic [1:0] idx);
      case (idx)
         2'd0:    byte_of = w[7:0];
         2'd1:    byte_of = w[15:8];
         default: byte_of = w[23:16];
      endcase
   endfunction

   // The requester that would win if granted this cycle, and whether its request is legal.
   // Write end address is formed one bit wider so addr+len never wraps back into range.
   always_comb begin
      req_any = r0_req | r1_req;
      if (r0_req && r1_req) begin
         grant_id = ~last_grant;
      end else begin
         grant_id = r1_req;
      end
      sel_write = grant_id ? r1_write : r0_write;
      sel_addr  = grant_id ? r1_addr  : r0_addr;
      sel_len   = grant_id ? r1_len   : r0_len;
      sel_wdata = grant_id ? r1_wdata : r0_wdata;
      if (sel_write) begin
         sel_fail = (ext_addr_t'(sel_addr) + ext_addr_t'(sel_len)) > MAX_EXT;
      end else begin
         sel_fail = ext_addr_t'(sel_addr) > MAX_EXT;
      end
   end

   // Next state plus the value every output takes in that next state, so outputs are registered.
   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      gnt_nxt        = gnt;
      lat_addr_nxt   = lat_addr;
      lat_len_nxt    = lat_len;
      lat_wdata_nxt  = lat_wdata;
      k_nxt          = k;
      k_inc          = k + 2'd1;
      s_read_nxt     = 1'b0;
      s_write_nxt    = 1'b0;
      s_address_nxt  = '0;
      s_data_nxt     = '0;
      r0_ack_nxt     = 1'b0;
      r0_err_nxt     = 1'b0;
      r1_ack_nxt     = 1'b0;
      r1_err_nxt     = 1'b0;

      case (state)
         IDLE: begin
            if (req_any) begin
               gnt_nxt        = grant_id;
               last_grant_nxt = grant_id;
               lat_addr_nxt   = sel_addr;
               lat_len_nxt    = sel_len;
               lat_wdata_nxt  = sel_wdata;
               k_nxt          = 2'd0;
               if (sel_fail) begin
                  state_nxt  = DONE;
                  r0_ack_nxt = ~grant_id;
                  r0_err_nxt = ~grant_id;
                  r1_ack_nxt = grant_id;
                  r1_err_nxt = grant_id;
               end else if (sel_write) begin
                  state_nxt     = WR;
                  s_write_nxt   = 1'b1;
                  s_address_nxt = sel_addr;
                  s_data_nxt    = sel_wdata[7:0];
               end else begin
                  state_nxt     = RD;
                  s_read_nxt    = 1'b1;
                  s_address_nxt = sel_addr;
               end
            end
         end
         WR: begin
            if (k == lat_len) begin
               state_nxt  = DONE;
               r0_ack_nxt = ~gnt;
               r1_ack_nxt = gnt;
            end else begin
               k_nxt         = k_inc;
               s_write_nxt   = 1'b1;
               s_address_nxt = lat_addr + ADDR_W'(k_inc);
               s_data_nxt    = byte_of(lat_wdata, k_inc);
            end
         end
         RD: begin
            state_nxt = RDWAIT;
         end
         RDWAIT: begin
            state_nxt  = DONE;
            r0_ack_nxt = ~gnt;
            r1_ack_nxt = gnt;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Register file returns data the cycle after s_read, which is the RDWAIT cycle.
   always_ff @(posedge fsm_clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         gnt        <= 1'b0;
         lat_addr   <= '0;
         lat_len    <= '0;
         lat_wdata  <= '0;
         k          <= '0;
         s_read     <= 1'b0;
         s_write    <= 1'b0;
         s_address  <= '0;
         s_data     <= '0;
         r0_ack     <= 1'b0;
         r0_err     <= 1'b0;
         r1_ack     <= 1'b0;
         r1_err     <= 1'b0;
         r0_rdata   <= '0;
         r1_rdata   <= '0;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
         gnt        <= gnt_nxt;
         lat_addr   <= lat_addr_nxt;
         lat_len    <= lat_len_nxt;
         lat_wdata  <= lat_wdata_nxt;
         k          <= k_nxt;
         s_read     <= s_read_nxt;
         s_write    <= s_write_nxt;
         s_address  <= s_address_nxt;
         s_data     <= s_data_nxt;
         r0_ack     <= r0_ack_nxt;
         r0_err     <= r0_err_nxt;
         r1_ack     <= r1_ack_nxt;
         r1_err     <= r1_err_nxt;
         if (state == RDWAIT) begin
            if (gnt) begin
               r1_rdata <= sb_read;
            end else begin
               r0_rdata <= sb_read;
            end
         end
      end
   end

endmodule
